// File: rtl/com_bus_arbiter_rr_pkg.sv
// ============================================================================
//  Module      : com_bus_arbiter_rr_pkg
//  Description : Shared types, defaults and the round-robin pick helper for
//                the common-bus arbiter of the MESI cache subsystem.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

package com_bus_arbiter_rr_pkg;

   // Default requester counts: DL caches occupy the low proc indices.
   localparam int N_PROC_DEF  = 8;
   localparam int N_SNOOP_DEF = 4;

   // Widest requester vector the pick helper can search.
   localparam int RR_MAX_W = 32;
   localparam int RR_IDX_W = 5;

   typedef logic [RR_IDX_W:0] rr_cnt_t;

   typedef enum logic [1:0] {
      P_IDLE = 2'd0,
      P_OWN  = 2'd1,
      P_TURN = 2'd2
   } proc_state_e;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } snoop_state_e;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of req at or after ptr, wrapping at width.
   // ptr must be below width; bits at or above width are ignored.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_W-1:0] req,
                                        input logic [RR_IDX_W-1:0] ptr,
                                        input rr_cnt_t             width);
      rr_pick_t res;
      rr_cnt_t  j;
      res = '0;
      for (int k = 0; k < RR_MAX_W; k++) begin
         j = {1'b0, ptr} + rr_cnt_t'(k);
         if (j >= width) begin
            j = j - width;
         end
         if ((rr_cnt_t'(k) < width) && !res.found && req[j[RR_IDX_W-1:0]]) begin
            res.found = 1'b1;
            res.idx   = j[RR_IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/com_bus_arbiter_rr_if.sv
// ============================================================================
//  Module      : com_bus_arbiter_rr_if
//  Description : Request/grant bundle between the per-cache Com_Bus ports and
//                the common-bus arbiter, plus arbiter status outputs.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

interface com_bus_arbiter_rr_if
   import com_bus_arbiter_rr_pkg::*;
#(
   parameter int N_PROC  = N_PROC_DEF,
   parameter int N_SNOOP = N_SNOOP_DEF
);
   localparam int OWNER_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;

   logic [N_PROC-1:0]  Com_Bus_Req_proc;
   logic [N_PROC-1:0]  Com_Bus_Gnt_proc;
   logic [N_SNOOP-1:0] Com_Bus_Req_snoop;
   logic [N_SNOOP-1:0] Com_Bus_Gnt_snoop;
   logic               bus_busy;
   logic [OWNER_W-1:0] proc_owner;
   logic               timeout_err;

   // Cache side: raises requests, watches grants and status.
   modport master (
      output Com_Bus_Req_proc,
      output Com_Bus_Req_snoop,
      input  Com_Bus_Gnt_proc,
      input  Com_Bus_Gnt_snoop,
      input  bus_busy,
      input  proc_owner,
      input  timeout_err
   );

   // Arbiter side.
   modport slave (
      input  Com_Bus_Req_proc,
      input  Com_Bus_Req_snoop,
      output Com_Bus_Gnt_proc,
      output Com_Bus_Gnt_snoop,
      output bus_busy,
      output proc_owner,
      output timeout_err
   );

endinterface

`default_nettype wire

// File: rtl/com_bus_arbiter_rr_picker.sv
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector: returns the first set
//                request at or after the pointer, wrapping at W.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module rr_picker
   import com_bus_arbiter_rr_pkg::*;
#(
   parameter int W  = 8,
   parameter int IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] idx_o,
   output logic          found_o
);

   rr_pick_t pick;
   logic     pick_idx_unused;

   // Search runs over the package helper, zero-extended to its fixed width.
   always_comb begin
      pick = rr_pick(RR_MAX_W'(req_i), RR_IDX_W'(ptr_i), rr_cnt_t'(W));
   end

   assign idx_o   = pick.idx[IW-1:0];
   assign found_o = pick.found;

   // Upper index bits are always zero for W below RR_MAX_W.
   assign pick_idx_unused = ^pick.idx;

endmodule

`default_nettype wire

// File: rtl/com_bus_arbiter_rr.sv
// ============================================================================
//  Module      : com_bus_arbiter_rr
//  Description : Common-bus arbiter. Round-robin processor channel with a
//                one-cycle turnaround and hold watchdog, plus an independent
//                round-robin snoop channel that may nest inside a processor
//                transaction.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module com_bus_arbiter_rr
   import com_bus_arbiter_rr_pkg::*;
#(
   parameter int N_PROC            = N_PROC_DEF,
   parameter int N_SNOOP           = N_SNOOP_DEF,
   parameter int MAX_HOLD          = 64,
   parameter bit REVOKE_ON_TIMEOUT = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   com_bus_arbiter_rr_if.slave bus
);

   localparam int PW = (N_PROC  > 1) ? $clog2(N_PROC)  : 1;
   localparam int SW = (N_SNOOP > 1) ? $clog2(N_SNOOP) : 1;
   localparam int HW = $clog2(MAX_HOLD + 1);

   localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);
   localparam logic [PW-1:0] PROC_LAST  = PW'(N_PROC - 1);
   localparam logic [SW-1:0] SNOOP_LAST = SW'(N_SNOOP - 1);

   // Processor channel state
   proc_state_e        p_state_q;
   logic [N_PROC-1:0]  gnt_proc_q;
   logic [PW-1:0]      owner_q;
   logic [PW-1:0]      p_ptr_q;
   logic               busy_q;
   logic [HW-1:0]      hold_q;
   logic               timeout_q;

   // Snoop channel state
   snoop_state_e       s_state_q;
   logic [N_SNOOP-1:0] gnt_snoop_q;
   logic [SW-1:0]      s_owner_q;
   logic [SW-1:0]      s_ptr_q;

   // Combinational helpers
   logic [PW-1:0]      proc_idx;
   logic               proc_found;
   logic [N_SNOOP-1:0] snoop_elig;
   logic [SW-1:0]      snoop_idx;
   logic               snoop_found;
   logic [HW-1:0]      hold_d;
   logic [PW-1:0]      p_ptr_d;
   logic [SW-1:0]      s_ptr_d;
   logic               release_p;

   rr_picker #(.W(N_PROC), .IW(PW)) u_proc_pick (
      .req_i   (bus.Com_Bus_Req_proc),
      .ptr_i   (p_ptr_q),
      .idx_o   (proc_idx),
      .found_o (proc_found)
   );

   // A core may not snoop its own transaction. While busy the proc grant is
   // the one-hot owner, so masking with its low bits removes exactly that DL.
   assign snoop_elig = bus.Com_Bus_Req_snoop & ~gnt_proc_q[N_SNOOP-1:0];

   rr_picker #(.W(N_SNOOP), .IW(SW)) u_snoop_pick (
      .req_i   (snoop_elig),
      .ptr_i   (s_ptr_q),
      .idx_o   (snoop_idx),
      .found_o (snoop_found)
   );

   assign hold_d  = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
   assign p_ptr_d = (owner_q == PROC_LAST) ? '0 : owner_q + PW'(1);
   assign s_ptr_d = (s_owner_q == SNOOP_LAST) ? '0 : s_owner_q + SW'(1);

   // Owner leaves on its own release, or is forced out when the watchdog
   // expires and revocation is enabled.
   assign release_p = !bus.Com_Bus_Req_proc[owner_q] ||
                      (REVOKE_ON_TIMEOUT && (hold_d == HOLD_MAX));

   // Processor FSM: grant, hold with watchdog, release into turnaround.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_state_q  <= P_IDLE;
         gnt_proc_q <= '0;
         owner_q    <= '0;
         p_ptr_q    <= '0;
         busy_q     <= 1'b0;
         hold_q     <= '0;
         timeout_q  <= 1'b0;
      end else begin
         unique case (p_state_q)
            P_IDLE: begin
               if (proc_found) begin
                  gnt_proc_q <= N_PROC'(1) << proc_idx;
                  owner_q    <= proc_idx;
                  busy_q     <= 1'b1;
                  hold_q     <= '0;
                  p_state_q  <= P_OWN;
               end
            end
            P_OWN: begin
               hold_q <= hold_d;
               if (hold_d == HOLD_MAX) begin
                  timeout_q <= 1'b1;
               end
               if (release_p) begin
                  gnt_proc_q <= '0;
                  busy_q     <= 1'b0;
                  p_ptr_q    <= p_ptr_d;
                  p_state_q  <= P_TURN;
               end
            end
            P_TURN: begin
               p_state_q <= P_IDLE;
            end
            default: begin
               p_state_q <= P_IDLE;
            end
         endcase
      end
   end

   // Snoop FSM: single grant at a time, no turnaround on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_state_q   <= S_IDLE;
         gnt_snoop_q <= '0;
         s_owner_q   <= '0;
         s_ptr_q     <= '0;
      end else begin
         unique case (s_state_q)
            S_IDLE: begin
               if (snoop_found) begin
                  gnt_snoop_q <= N_SNOOP'(1) << snoop_idx;
                  s_owner_q   <= snoop_idx;
                  s_state_q   <= S_OWN;
               end
            end
            S_OWN: begin
               if (!bus.Com_Bus_Req_snoop[s_owner_q]) begin
                  gnt_snoop_q <= '0;
                  s_ptr_q     <= s_ptr_d;
                  s_state_q   <= S_IDLE;
               end
            end
            default: begin
               s_state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.Com_Bus_Gnt_proc  = gnt_proc_q;
   assign bus.Com_Bus_Gnt_snoop = gnt_snoop_q;
   assign bus.bus_busy          = busy_q;
   assign bus.proc_owner        = owner_q;
   assign bus.timeout_err       = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_com_bus_arbiter_rr.sv
// ============================================================================
//  Module      : tb_com_bus_arbiter_rr
//  Description : Self-checking bench for com_bus_arbiter_rr (8 proc, 4 snoop,
//                MAX_HOLD 8, revoke on timeout).
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_com_bus_arbiter_rr;

   localparam int NP = 8;
   localparam int NS = 4;
   localparam int MH = 8;

   typedef struct {
      logic       rst;
      logic [7:0] rp;
      logic [3:0] rs;
      logic [7:0] gp;
      logic [3:0] gs;
      logic       busy;
      logic [2:0] own;
      logic       tmo;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vec_t tbl[$];
   vec_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   vec_no  = 0;

   com_bus_arbiter_rr_if #(.N_PROC(NP), .N_SNOOP(NS)) bif ();

   com_bus_arbiter_rr #(
      .N_PROC            (NP),
      .N_SNOOP           (NS),
      .MAX_HOLD          (MH),
      .REVOKE_ON_TIMEOUT (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   // Free-running clock
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [7:0] rp, input logic [3:0] rs,
                               input logic [7:0] gp, input logic [3:0] gs,
                               input logic b, input logic [2:0] o, input logic t);
      vec_t v;
      v.rst = r; v.rp = rp; v.rs = rs; v.gp = gp; v.gs = gs;
      v.busy = b; v.own = o; v.tmo = t;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0h expected %0h", nm, vec_no, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input vec_t v);
      vec_t e;
      rst = v.rst;
      bif.Com_Bus_Req_proc  = v.rp;
      bif.Com_Bus_Req_snoop = v.rs;
      sb_q.push_back(v);
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      check("gnt_proc",    32'(bif.Com_Bus_Gnt_proc),  32'(e.gp));
      check("gnt_snoop",   32'(bif.Com_Bus_Gnt_snoop), 32'(e.gs));
      check("bus_busy",    32'(bif.bus_busy),          32'(e.busy));
      check("timeout_err", 32'(bif.timeout_err),       32'(e.tmo));
      if (e.busy || e.rst) begin
         check("proc_owner", 32'(bif.proc_owner), 32'(e.own));
      end
      vec_no++;
   endtask

   // Grant vectors must be one-hot-or-zero at every cycle.
   always @(negedge clk) begin
      n_tests++;
      if (!$onehot0(bif.Com_Bus_Gnt_proc) || !$onehot0(bif.Com_Bus_Gnt_snoop)) begin
         n_fail++;
         $display("FAIL onehot0 at %0t: gnt_proc %0h gnt_snoop %0h required one-hot-or-zero",
                  $time, bif.Com_Bus_Gnt_proc, bif.Com_Bus_Gnt_snoop);
      end
   end

   // Run-time bound
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e;
      bif.Com_Bus_Req_proc  = '0;
      bif.Com_Bus_Req_snoop = '0;

      // Mid-op reset: owner 4 + snoop 1, pointers moved, then rst clears all.
      tbl.push_back(mk(0, 8'h10, 4'h2, 8'h10, 4'h2, 1, 3'd4, 0));
      tbl.push_back(mk(0, 8'h10, 4'h0, 8'h10, 4'h0, 1, 3'd4, 0));
      tbl.push_back(mk(0, 8'h10, 4'h2, 8'h10, 4'h2, 1, 3'd4, 0));
      tbl.push_back(mk(1, 8'h10, 4'h2, 8'h00, 4'h0, 0, 3'd0, 0));
      // Pointers back at 0: proc picks 0 (not 1), snoop picks 1 (not 2).
      tbl.push_back(mk(0, 8'hFF, 4'h6, 8'h01, 4'h2, 1, 3'd0, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(1, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      // Single request, hold, release, turnaround.
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 8'h04, 4'h0, 8'h04, 4'h0, 1, 3'd2, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      // Release and new request in the same cycle: new one waits out P_TURN.
      tbl.push_back(mk(0, 8'h02, 4'h0, 8'h02, 4'h0, 1, 3'd1, 0));
      tbl.push_back(mk(0, 8'h01, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h0, 8'h01, 4'h0, 1, 3'd0, 0));
      // Request withdrawn during turnaround is never granted.
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h08, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      // Nested snoop: core 0 owns; snoop 0 masked until it releases.
      tbl.push_back(mk(0, 8'h01, 4'h0, 8'h01, 4'h0, 1, 3'd0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h3, 8'h01, 4'h2, 1, 3'd0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h3, 8'h01, 4'h2, 1, 3'd0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h1, 8'h01, 4'h0, 1, 3'd0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h1, 8'h01, 4'h0, 1, 3'd0, 0));
      tbl.push_back(mk(0, 8'h00, 4'h1, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h00, 4'h1, 8'h00, 4'h1, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      // Proc and snoop granted on the same edge.
      tbl.push_back(mk(0, 8'h20, 4'h4, 8'h20, 4'h4, 1, 3'd5, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      // Wrap-around: move pointer to 7, then 0x81 grants 7 then 0.
      tbl.push_back(mk(0, 8'h40, 4'h0, 8'h40, 4'h0, 1, 3'd6, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h81, 4'h0, 8'h80, 4'h0, 1, 3'd7, 0));
      tbl.push_back(mk(0, 8'h01, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h0, 8'h01, 4'h0, 1, 3'd0, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      // Timeout: owner 3 held 8 cycles, revoked, sticky flag, 4 then 3 again.
      tbl.push_back(mk(0, 8'h08, 4'h0, 8'h08, 4'h0, 1, 3'd3, 0));
      for (int i = 0; i < MH - 1; i++) tbl.push_back(mk(0, 8'h18, 4'h0, 8'h08, 4'h0, 1, 3'd3, 0));
      tbl.push_back(mk(0, 8'h18, 4'h0, 8'h00, 4'h0, 0, 3'd0, 1));
      tbl.push_back(mk(0, 8'h18, 4'h0, 8'h00, 4'h0, 0, 3'd0, 1));
      tbl.push_back(mk(0, 8'h18, 4'h0, 8'h10, 4'h0, 1, 3'd4, 1));
      tbl.push_back(mk(0, 8'h08, 4'h0, 8'h00, 4'h0, 0, 3'd0, 1));
      tbl.push_back(mk(0, 8'h08, 4'h0, 8'h00, 4'h0, 0, 3'd0, 1));
      tbl.push_back(mk(0, 8'h08, 4'h0, 8'h08, 4'h0, 1, 3'd3, 1));
      tbl.push_back(mk(0, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 1));
      tbl.push_back(mk(1, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));

      @(negedge clk);
      // Reset state
      apply(mk(1, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
      apply(mk(1, 8'h00, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));

      // Fairness: all requesting, each owner holds 3 cycles then drops for one.
      e = 0;
      for (int g = 0; g < NP + 1; g++) begin
         for (int c = 0; c < 3; c++) begin
            apply(mk(0, 8'hFF, 4'h0, 8'(1 << e), 4'h0, 1, 3'(e), 0));
         end
         apply(mk(0, 8'hFF & ~8'(1 << e), 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
         apply(mk(0, 8'hFF, 4'h0, 8'h00, 4'h0, 0, 3'd0, 0));
         e = (e + 1) % NP;
      end

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
